// File: rtl/spi_prot_trig.sv
// Passive SPI frame monitor: synchronizes SS_n/SCLK/MOSI, captures a frame
// and pulses SPItrig when it equals the masked match value.
module spi_prot_trig #(
    parameter int MAX_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                SS_n,
    input  logic                SCLK,
    input  logic                MOSI,
    input  logic                edg,
    input  logic                len8,
    input  logic [MAX_BITS-1:0] match,
    input  logic [MAX_BITS-1:0] mask,
    output logic                SPItrig,
    output logic [MAX_BITS-1:0] rx_data,
    output logic                frm_err
);

    typedef enum logic [1:0] {IDLE, ARMED, RX, CHECK} state_t;

    localparam logic [4:0] CNT_FULL = 5'(MAX_BITS);
    localparam logic [4:0] CNT_SAT  = 5'(MAX_BITS + 1);

    state_t              state;
    state_t              state_nxt;
    logic [2:0]          ss_ff;
    logic [2:0]          sclk_ff;
    logic [2:0]          mosi_ff;
    logic [1:0]          warm;
    logic                fall_hold;
    logic [MAX_BITS-1:0] shft;
    logic [4:0]          bit_cnt;

    logic ss_fall;
    logic ss_rise;
    logic sclk_edge;
    logic start;
    logic good;
    logic hit;

    assign ss_fall   = ss_ff[2] & ~ss_ff[1];
    assign ss_rise   = ~ss_ff[2] & ss_ff[1];
    assign sclk_edge = edg ? (~sclk_ff[2] & sclk_ff[1])
                           : (sclk_ff[2] & ~sclk_ff[1]);
    assign start     = ss_fall | fall_hold;

    assign good = (bit_cnt == (len8 ? 5'd8 : CNT_FULL));
    assign hit  = len8 ? &((shft[7:0] ~^ match[7:0]) | mask[7:0])
                       : &((shft ~^ match) | mask);

    // warm keeps IDLE from trusting the preset sync flops before real pin data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_ff     <= 3'b111;
            sclk_ff   <= 3'b111;
            mosi_ff   <= 3'b000;
            warm      <= 2'd0;
            fall_hold <= 1'b0;
        end else begin
            ss_ff     <= {ss_ff[1:0], SS_n};
            sclk_ff   <= {sclk_ff[1:0], SCLK};
            mosi_ff   <= {mosi_ff[1:0], MOSI};
            fall_hold <= ss_fall;
            if (warm != 2'd2)
                warm <= warm + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (warm == 2'd2 && ss_ff[1]) state_nxt = ARMED;
            ARMED: if (start) state_nxt = RX;
            RX:    if (ss_rise) state_nxt = CHECK;
            CHECK: state_nxt = ARMED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shft    <= '0;
            bit_cnt <= 5'd0;
            rx_data <= '0;
            SPItrig <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            SPItrig <= 1'b0;
            frm_err <= 1'b0;
            unique case (state)
                IDLE: bit_cnt <= 5'd0;
                ARMED: begin
                    if (start) begin
                        shft    <= '0;
                        bit_cnt <= 5'd0;
                    end
                end
                RX: begin
                    if (sclk_edge && !ss_rise) begin
                        shft <= {shft[MAX_BITS-2:0], mosi_ff[2]};
                        if (bit_cnt != CNT_SAT)
                            bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                CHECK: begin
                    SPItrig <= good & hit;
                    frm_err <= ~good;
                    if (good)
                        rx_data <= len8 ? {{(MAX_BITS-8){1'b0}}, shft[7:0]}
                                        : shft;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_prot_trig.sv
// Bench for spi_prot_trig: directed scenarios plus random frames checked
// against a frame-level reference model.
module tb_spi_prot_trig;

    logic        clk = 1'b0;
    logic        rst;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        edg;
    logic        len8;
    logic [15:0] match;
    logic [15:0] mask;
    logic        SPItrig;
    logic [15:0] rx_data;
    logic        frm_err;

    spi_prot_trig dut (
        .clk     (clk),
        .rst     (rst),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .edg     (edg),
        .len8    (len8),
        .match   (match),
        .mask    (mask),
        .SPItrig (SPItrig),
        .rx_data (rx_data),
        .frm_err (frm_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int trig_cnt = 0;
    int err_cnt = 0;
    int trig_cyc = -1;
    int t_rise = 0;
    logic [15:0] ref_rx = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (SPItrig) begin
            trig_cnt <= trig_cnt + 1;
            trig_cyc <= cyc;
        end
        if (frm_err)
            err_cnt <= err_cnt + 1;
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(int nbits, logic [31:0] data, int h);
        for (int i = nbits - 1; i >= 0; i--) begin
            MOSI = data[i];
            idle(h);
            SCLK = ~SCLK;
            idle(h);
            SCLK = ~SCLK;
        end
    endtask

    task automatic set_mode(bit l8, bit e);
        len8 = l8;
        edg  = e;
        SCLK = e ? 1'b0 : 1'b1;
        idle(6);
    endtask

    // coinc: a sampling SCLK edge lands together with the SS_n rise
    task automatic send_frame(int nbits, logic [31:0] data, int h, bit coinc);
        SS_n = 1'b0;
        idle(h);
        shift_bits(nbits, data, h);
        idle(h);
        if (coinc) begin
            MOSI = 1'($urandom);
            SCLK = ~SCLK;
        end
        SS_n = 1'b1;
        t_rise = cyc;
        if (coinc) begin
            idle(h);
            SCLK = ~SCLK;
        end
    endtask

    task automatic run_frame(string tag, int nbits, logic [31:0] data,
                             int h, bit coinc);
        int          t0;
        int          e0;
        logic [15:0] val;
        logic [15:0] wm;
        bit          good;
        bit          hit;
        t0 = trig_cnt;
        e0 = err_cnt;
        send_frame(nbits, data, h, coinc);
        idle(14);
        val  = data[15:0];
        wm   = len8 ? 16'h00FF : 16'hFFFF;
        good = (nbits == (len8 ? 8 : 16));
        hit  = (((val ^ match) & ~mask & wm) == 16'h0000);
        if (good)
            ref_rx = val & wm;
        check({tag, " trig"}, 32'(trig_cnt - t0), 32'(good && hit));
        if (good && hit)
            check({tag, " lat"}, 32'(trig_cyc - t_rise), 32'd4);
        check({tag, " err"}, 32'(err_cnt - e0), 32'(!good));
        check({tag, " rx"}, 32'(rx_data), 32'(ref_rx));
    endtask

    initial begin
        int t0;
        int e0;
        rst   = 1'b1;
        SS_n  = 1'b1;
        SCLK  = 1'b1;
        MOSI  = 1'b0;
        edg   = 1'b1;
        len8  = 1'b1;
        match = 16'h0000;
        mask  = 16'h0000;
        idle(3);
        check("rst trig", 32'(SPItrig), 32'd0);
        check("rst rx", 32'(rx_data), 32'd0);
        check("rst err", 32'(frm_err), 32'd0);
        rst = 1'b0;
        idle(4);

        set_mode(1'b1, 1'b1);
        match = 16'h0066;
        mask  = 16'h0000;
        run_frame("t1", 8, 32'h66, 4, 1'b0);
        run_frame("t2", 8, 32'h67, 4, 1'b0);
        match = 16'h0060;
        mask  = 16'h000F;
        run_frame("t3", 8, 32'h6A, 4, 1'b0);

        set_mode(1'b0, 1'b0);
        match = 16'hA5C3;
        mask  = 16'h0000;
        run_frame("t4 16b", 16, 32'hA5C3, 4, 1'b0);
        run_frame("t4 15b", 15, 32'h1234, 4, 1'b0);
        run_frame("t4 17b", 17, 32'h1ABCD, 4, 1'b0);
        check("t4 rx held", 32'(rx_data), 32'h0000A5C3);

        set_mode(1'b1, 1'b1);
        match = 16'h0066;
        mask  = 16'h0000;
        t0 = trig_cnt;
        e0 = err_cnt;
        SS_n = 1'b0;
        idle(4);
        shift_bits(4, 32'h6, 4);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        ref_rx = 16'h0000;
        check("t5 rx rst", 32'(rx_data), 32'd0);
        shift_bits(4, 32'h6, 4);
        idle(4);
        SS_n = 1'b1;
        idle(14);
        check("t5 trig", 32'(trig_cnt - t0), 32'd0);
        check("t5 err", 32'(err_cnt - e0), 32'd0);
        run_frame("t5 next", 8, 32'h66, 4, 1'b0);

        t0 = trig_cnt;
        e0 = err_cnt;
        send_frame(8, 32'h66, 4, 1'b0);
        idle(4);
        send_frame(8, 32'h66, 4, 1'b1);
        idle(14);
        check("t6 trig", 32'(trig_cnt - t0), 32'd2);
        check("t6 err", 32'(err_cnt - e0), 32'd0);
        check("t6 lat", 32'(trig_cyc - t_rise), 32'd4);

        for (int k = 0; k < 40; k++) begin
            int          nb;
            int          expn;
            int          r;
            logic [31:0] d;
            set_mode(1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                SCLK = ~SCLK;
                idle(3);
                SCLK = ~SCLK;
                idle(6);
            end
            expn = len8 ? 8 : 16;
            r = $urandom_range(0, 9);
            if (r <= 6)
                nb = expn;
            else if (r == 7)
                nb = expn - 1;
            else if (r == 8)
                nb = expn + 1;
            else
                nb = $urandom_range(0, 20);
            d = $urandom;
            if (nb < 32)
                d = d & ((32'd1 << nb) - 32'd1);
            match = ($urandom_range(0, 1) == 1) ? d[15:0] : 16'($urandom);
            mask  = 16'($urandom & $urandom & $urandom);
            run_frame($sformatf("rnd%0d", k), nb, d,
                      $urandom_range(3, 5), 1'($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
